gsim_mat_prep: RTL

Upstream preprocessing stage for the Gauss-Seidel solver. It accepts raw matrix problems (A rows, then b) as a stream of 256-bit beats and replaces each diagonal entry a_rr with its Q2.14 reciprocal, computed by a sequential divider. It writes the result into the matrix memory in the exact layout the solver reads: row r of matrix m at address m*17+r (r=0..15), and b at m*17+16. Off-diagonal entries and b pass through unchanged.

---
 rtl/gsim_pkg.sv | 14 +
 rtl/gsim_recip_div.sv | 49 ++++
 rtl/gsim_mat_prep.sv | 119 +++++++++++
 3 files changed

// File: rtl/gsim_pkg.sv
// gsim_pkg: shared types and constants for the Gauss-Seidel matrix preparation stage
package gsim_pkg;
    typedef enum logic [2:0] {IDLE, RECV, DIV, WRITE, DONE} state_t;
    localparam int MAT_ROWS     = 16;
    localparam int ROWS_PER_MAT = 17;
    localparam int RECIP_FRAC   = 14;
    localparam int ADDR_W       = 10;
    localparam int LANE_W       = 16;
    localparam logic [LANE_W-1:0] RECIP_ZERO = 16'h7FFF;

    function automatic logic [LANE_W-1:0] abs16(input logic [LANE_W-1:0] v);
        return v[LANE_W-1] ? LANE_W'(-v) : v;
    endfunction
endpackage

// File: rtl/gsim_recip_div.sv
// gsim_recip_div: restoring radix-2 divider computing 2^RECIP_FRAC / divisor in 15 iterations
module gsim_recip_div
    import gsim_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] divisor,
    output logic [14:0] quotient,
    output logic        done
);
    logic [16:0] rem, rem_in, shifted, rem_nx;
    logic [14:0] dvd, dvd_in, quo_in;
    logic [15:0] dsr, d_in;
    logic [3:0]  cnt;
    logic        ge;

    // one shift-subtract step; the start cycle already performs the first iteration
    always_comb begin
        rem_in  = start ? '0 : rem;
        dvd_in  = start ? 15'(1 << RECIP_FRAC) : dvd;
        quo_in  = start ? '0 : quotient;
        d_in    = start ? divisor : dsr;
        shifted = 17'({rem_in, dvd_in[14]});
        ge      = shifted >= 17'(d_in);
        rem_nx  = ge ? shifted - 17'(d_in) : shifted;
    end

    // iteration counter runs 1..15; done is raised for the cycle after the 15th step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            quotient <= '0;
            cnt      <= '0;
            done     <= 1'b0;
        end else if (start || (cnt != 4'd0 && cnt != 4'd15)) begin
            rem      <= rem_nx;
            dvd      <= dvd_in << 1;
            dsr      <= d_in;
            quotient <= 15'({quo_in, ge});
            cnt      <= start ? 4'd1 : cnt + 4'd1;
            done     <= !start && cnt == 4'd14;
        end else begin
            done <= 1'b0;
        end
    end
endmodule

// File: rtl/gsim_mat_prep.sv
// gsim_mat_prep: replaces each matrix diagonal with its Q2.14 reciprocal and writes rows in solver layout
module gsim_mat_prep
    import gsim_pkg::*;
(
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic [4:0]                   i_matrix_num,
    input  logic                         i_row_valid,
    output logic                         o_row_ready,
    input  logic [MAT_ROWS*LANE_W-1:0]   i_row_data,
    output logic                         o_wen,
    output logic [ADDR_W-1:0]            o_addr,
    output logic [MAT_ROWS*LANE_W-1:0]   o_wdata,
    output logic                         o_busy,
    output logic                         o_prep_done
);
    state_t                       state;
    logic [4:0]                   num, mat, row;
    logic [MAT_ROWS*LANE_W-1:0]   beat, row_out;
    logic                         neg, zero, xfer, div_start, div_done;
    logic [LANE_W-1:0]            lane, mag, q_s;
    logic [14:0]                  quo;
    logic [ADDR_W-1:0]            addr;

    gsim_recip_div u_div (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .start    (div_start),
        .divisor  (mag),
        .quotient (quo),
        .done     (div_done)
    );

    // diagonal lane selection, signed reciprocal and row/address assembly
    always_comb begin
        xfer      = state == RECV && i_row_valid && o_row_ready;
        div_start = xfer && row != 5'd16;
        lane      = i_row_data[{row[3:0], 4'b0} +: LANE_W];
        mag       = abs16(lane);
        q_s       = zero ? RECIP_ZERO : neg ? LANE_W'(-{1'b0, quo}) : {1'b0, quo};
        row_out   = beat;
        row_out[{row[3:0], 4'b0} +: LANE_W] = q_s;
        addr      = ADDR_W'({mat, 4'b0}) + ADDR_W'(mat) + ADDR_W'(row);
    end

    // control FSM with all outputs registered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            num         <= '0;
            mat         <= '0;
            row         <= '0;
            beat        <= '0;
            neg         <= 1'b0;
            zero        <= 1'b0;
            o_row_ready <= 1'b0;
            o_wen       <= 1'b0;
            o_addr      <= '0;
            o_wdata     <= '0;
            o_busy      <= 1'b0;
            o_prep_done <= 1'b0;
        end else begin
            o_wen       <= 1'b0;
            o_prep_done <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    num    <= i_matrix_num;
                    mat    <= '0;
                    row    <= '0;
                    o_busy <= 1'b1;
                    if (i_matrix_num == 5'd0) begin
                        state       <= DONE;
                        o_prep_done <= 1'b1;
                    end else begin
                        state       <= RECV;
                        o_row_ready <= 1'b1;
                    end
                end
                RECV: if (xfer) begin
                    o_row_ready <= 1'b0;
                    beat        <= i_row_data;
                    if (row == 5'd16) begin
                        state   <= WRITE;
                        o_wen   <= 1'b1;
                        o_addr  <= addr;
                        o_wdata <= i_row_data;
                    end else begin
                        state <= DIV;
                        neg   <= lane[LANE_W-1];
                        zero  <= lane == '0;
                    end
                end
                DIV: if (div_done) begin
                    state   <= WRITE;
                    o_wen   <= 1'b1;
                    o_addr  <= addr;
                    o_wdata <= row_out;
                end
                WRITE: begin
                    row <= row == 5'd16 ? 5'd0 : row + 5'd1;
                    mat <= row == 5'd16 ? mat + 5'd1 : mat;
                    if (row == 5'd16 && mat == num - 5'd1) begin
                        state       <= DONE;
                        o_prep_done <= 1'b1;
                    end else begin
                        state       <= RECV;
                        o_row_ready <= 1'b1;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
